// File: rtl/codec_i2c_pkg.sv
// ---------------------------------------------------------------------------
// codec_i2c_pkg
// Definitions shared by the codec register writer and the I2C byte engine:
//   - engine op encoding (IDLE / WRITE / READ)
//   - register-writer FSM state enum
//   - bit_rev8: byte reversal, used when the engine shifts LSB first
// ---------------------------------------------------------------------------
package codec_i2c_pkg;

    localparam logic [1:0] C_OP_IDLE  = 2'd0;
    localparam logic [1:0] C_OP_WRITE = 2'd1;
    localparam logic [1:0] C_OP_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_SEND  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } wr_state_t;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/codec_reg_writer.sv
// ---------------------------------------------------------------------------
// codec_reg_writer
// Turns one codec register write (7-bit reg address, 9-bit data) into the
// three-byte I2C write {dev_addr,W} / {reg_addr,data[8]} / data[7:0] and
// drives the byte engine through it. Each byte window is timed locally. The
// slave ACK is checked after every byte, and a NACK restarts the whole
// transaction up to C_MAX_RETRY times.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_addr, cmd_data  register address / data, latched on accept
//   busy                high from accept until the done / error pulse
//   done                1-cycle pulse: all three bytes ACKed
//   nack_err            1-cycle pulse: retries exhausted
//   err_sticky          set with nack_err, cleared only by rst
//   eng_op, eng_wdata   command and byte to the I2C byte engine
//   eng_ack             ACK bit the engine sampled (1 = NACK)
// ---------------------------------------------------------------------------
module codec_reg_writer
    import codec_i2c_pkg::*;
#(
    parameter logic [15:0] C_CLK_DIVISOR = 16'd2,
    parameter logic [6:0]  C_DEV_ADDR    = 7'h1A,
    parameter logic [7:0]  C_GAP_CYCLES  = 8'd4,
    parameter logic [1:0]  C_MAX_RETRY   = 2'd2,
    parameter logic        C_LSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [8:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic       err_sticky,
    output logic [1:0] eng_op,
    output logic [7:0] eng_wdata,
    input  logic       eng_ack
);

    // One byte window: 8 data bits plus the ACK bit, each C_CLK_DIVISOR+1 clocks.
    localparam logic [19:0] C_BYTE_CYCLES = 20'd9 * (20'(C_CLK_DIVISOR) + 20'd1);
    localparam logic [19:0] C_BYTE_LAST   = C_BYTE_CYCLES - 20'd1;
    localparam logic [19:0] C_GAP_LAST    = 20'(C_GAP_CYCLES) - 20'd1;

    wr_state_t   state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic [19:0] cyc_q, cyc_d;
    logic [23:0] frame_q, frame_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        sticky_q, sticky_d;
    logic [7:0]  cur_byte;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        cyc_d    = cyc_q;
        frame_d  = frame_q;
        wdata_d  = wdata_q;
        sticky_d = sticky_q;

        case (idx_q)
            2'd0:    cur_byte = frame_q[23:16];
            2'd1:    cur_byte = frame_q[15:8];
            default: cur_byte = frame_q[7:0];
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    frame_d = {C_DEV_ADDR, 1'b0, cmd_addr, cmd_data};
                    idx_d   = 2'd0;
                    retry_d = 2'd0;
                    cyc_d   = 20'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Byte is loaded while op is IDLE so it is settled before WRITE.
                wdata_d = C_LSB_FIRST ? bit_rev8(cur_byte) : cur_byte;
                if (cyc_q == C_GAP_LAST) begin
                    cyc_d   = 20'd0;
                    state_d = S_SEND;
                end else begin
                    cyc_d = cyc_q + 20'd1;
                end
            end
            S_SEND: begin
                if (cyc_q == C_BYTE_LAST) begin
                    cyc_d   = 20'd0;
                    state_d = S_CHECK;
                end else begin
                    cyc_d = cyc_q + 20'd1;
                end
            end
            S_CHECK: begin
                cyc_d = 20'd0;
                if (!eng_ack) begin
                    if (idx_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_GAP;
                    end
                end else if (retry_q < C_MAX_RETRY) begin
                    // Whole transaction restarts from the device address byte.
                    retry_d = retry_q + 2'd1;
                    idx_d   = 2'd0;
                    state_d = S_GAP;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                sticky_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            retry_q  <= 2'd0;
            cyc_q    <= 20'd0;
            wdata_q  <= 8'hFF;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            cyc_q    <= cyc_d;
            wdata_q  <= wdata_d;
            sticky_q <= sticky_d;
        end
    end

    // Command frame is pure data; a new accept always overwrites it.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    // Outputs decode directly from the state register, so a reset returns
    // eng_op to IDLE and drops busy within one cycle. CHECK keeps WRITE so
    // the engine's ACK capture is not cleared before it is sampled.
    always_comb begin
        eng_op     = C_OP_IDLE;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        nack_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SEND, S_CHECK: eng_op   = C_OP_WRITE;
            S_DONE:          done     = 1'b1;
            S_ERR:           nack_err = 1'b1;
            default:         eng_op   = C_OP_IDLE;
        endcase
    end

    assign eng_wdata  = wdata_q;
    assign err_sticky = sticky_q;

endmodule
